// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control block: controller state
// encoding, the all-zero control word used to build bubbles, and the
// stage-register indices used for the write-enable/flush vectors.
package pipe_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } pipe_state_e;

  // Stage-register indices into the per-stage enable/flush vectors.
  localparam int STG_IFID  = 0;
  localparam int STG_IDEX  = 1;
  localparam int STG_EXMEM = 2;
  localparam int STG_MEMWB = 3;
  localparam int NUM_STG   = 4;

  // Control-zero word: no stage enabled / no stage flushed.
  localparam logic [NUM_STG-1:0] CTRL_ZERO = '0;
  // Every stage register loads a bubble.
  localparam logic [NUM_STG-1:0] BUBBLE_ALL = '1;

  // One-hot stage mask helper.
  function automatic logic [NUM_STG-1:0] stg_mask(input int idx);
    logic [NUM_STG-1:0] m;
    m      = CTRL_ZERO;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Count up on inc, hold at all-ones, clear on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard control: converts load-use stall, taken branch and
// data-memory wait into per-stage write enables and flushes, runs a
// full-pipeline flush after reset, flags data-memory timeouts and keeps
// saturating hazard performance counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Need_Stall,
  input  logic             EX__Branch_Taken,
  input  logic             EXmem__MemEnable,
  input  logic             Mem_Ready,
  input  logic             IF__Imem_Ready,
  input  logic             Clr_Cnt,
  output logic             PC_En,
  output logic             IFid__WE,
  output logic             IDex__WE,
  output logic             EXmem__WE,
  output logic             MEMwb__WE,
  output logic             IFid__Flush,
  output logic             IDex__Flush,
  output logic             EXmem__Flush,
  output logic             MEMwb__Flush,
  output logic             Mem_Err,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt,
  output logic [CNT_W-1:0] Wait_Cnt
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  pipe_state_e         state_q, state_d;
  logic [INIT_W-1:0]   init_cnt_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                init_last;
  logic                mw;
  logic                stall_hit;
  logic                flush_hit;
  logic                wait_hit;
  logic                pc_en;
  logic [NUM_STG-1:0]  stg_we;
  logic [NUM_STG-1:0]  stg_flush;

  assign mw        = EXmem__MemEnable && !Mem_Ready;
  assign init_last = (init_cnt_q == INIT_W'(INIT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and same-cycle stage controls, highest-priority hazard first.
  always_comb begin
    state_d   = state_q;
    pc_en     = 1'b0;
    stg_we    = CTRL_ZERO;
    stg_flush = BUBBLE_ALL;
    stall_hit = 1'b0;
    flush_hit = 1'b0;
    wait_hit  = 1'b0;
    case (state_q)
      INIT: begin
        if (init_last) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = RUN;
        pc_en     = 1'b1;
        stg_we    = BUBBLE_ALL;
        stg_flush = CTRL_ZERO;
        if (mw) begin
          // Hold everything; MEM_WB takes a bubble while the load is pending.
          state_d   = MEM_WAIT;
          pc_en     = 1'b0;
          stg_we    = CTRL_ZERO;
          stg_flush = stg_mask(STG_MEMWB);
          wait_hit  = 1'b1;
        end else if (Need_Stall) begin
          // Freeze PC/IF_ID/ID_EX, bubble into EX_MEM, let MEM_WB drain.
          pc_en     = 1'b0;
          stg_we    = stg_mask(STG_MEMWB);
          stg_flush = stg_mask(STG_EXMEM);
          stall_hit = 1'b1;
        end else if (EX__Branch_Taken) begin
          // Redirect PC and squash the two younger instructions.
          stg_we    = stg_mask(STG_EXMEM) | stg_mask(STG_MEMWB);
          stg_flush = stg_mask(STG_IFID) | stg_mask(STG_IDEX);
          flush_hit = 1'b1;
        end else if (!IF__Imem_Ready) begin
          // No fetched word: hold PC, bubble into IF_ID, rest advances.
          pc_en     = 1'b0;
          stg_we    = stg_mask(STG_IDEX) | stg_mask(STG_EXMEM) | stg_mask(STG_MEMWB);
          stg_flush = stg_mask(STG_IFID);
        end
      end
    endcase
  end

  // Post-reset flush length counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt_q <= '0;
    end else if ((state_q == INIT) && !init_last) begin
      init_cnt_q <= init_cnt_q + INIT_W'(1);
    end
  end

  // Consecutive memory-wait length and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      Mem_Err    <= 1'b0;
    end else if (wait_hit) begin
      if (wait_cnt_q != WAIT_W'(MEM_TIMEOUT)) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end
      if (wait_cnt_q >= WAIT_W'(MEM_TIMEOUT - 1)) begin
        Mem_Err <= 1'b1;
      end
    end else begin
      wait_cnt_q <= '0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_hit),
    .clr   (Clr_Cnt),
    .cnt   (Stall_Cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_hit),
    .clr   (Clr_Cnt),
    .cnt   (Flush_Cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wait_hit),
    .clr   (Clr_Cnt),
    .cnt   (Wait_Cnt)
  );

  assign PC_En        = pc_en;
  assign IFid__WE     = stg_we[STG_IFID];
  assign IDex__WE     = stg_we[STG_IDEX];
  assign EXmem__WE    = stg_we[STG_EXMEM];
  assign MEMwb__WE    = stg_we[STG_MEMWB];
  assign IFid__Flush  = stg_flush[STG_IFID];
  assign IDex__Flush  = stg_flush[STG_IDEX];
  assign EXmem__Flush = stg_flush[STG_EXMEM];
  assign MEMwb__Flush = stg_flush[STG_MEMWB];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic,
// each cycle compared against a rule-level reference model.
module tb_pipe_ctrl;

  localparam int INIT_CYCLES = 4;
  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_W       = 4;
  localparam int CMAX        = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             Need_Stall = 1'b0;
  logic             EX__Branch_Taken = 1'b0;
  logic             EXmem__MemEnable = 1'b0;
  logic             Mem_Ready = 1'b0;
  logic             IF__Imem_Ready = 1'b1;
  logic             Clr_Cnt = 1'b0;
  logic             PC_En;
  logic             IFid__WE, IDex__WE, EXmem__WE, MEMwb__WE;
  logic             IFid__Flush, IDex__Flush, EXmem__Flush, MEMwb__Flush;
  logic             Mem_Err;
  logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt, Wait_Cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int init_left;
  int wait_run;
  bit m_err;
  int m_sc, m_fc, m_wc;

  pipe_ctrl #(
    .INIT_CYCLES (INIT_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .Need_Stall       (Need_Stall),
    .EX__Branch_Taken (EX__Branch_Taken),
    .EXmem__MemEnable (EXmem__MemEnable),
    .Mem_Ready        (Mem_Ready),
    .IF__Imem_Ready   (IF__Imem_Ready),
    .Clr_Cnt          (Clr_Cnt),
    .PC_En            (PC_En),
    .IFid__WE         (IFid__WE),
    .IDex__WE         (IDex__WE),
    .EXmem__WE        (EXmem__WE),
    .MEMwb__WE        (MEMwb__WE),
    .IFid__Flush      (IFid__Flush),
    .IDex__Flush      (IDex__Flush),
    .EXmem__Flush     (EXmem__Flush),
    .MEMwb__Flush     (MEMwb__Flush),
    .Mem_Err          (Mem_Err),
    .Stall_Cnt        (Stall_Cnt),
    .Flush_Cnt        (Flush_Cnt),
    .Wait_Cnt         (Wait_Cnt)
  );

  always #5 clk = ~clk;

  // Control word layout: {PC_En, WE[IF,ID,EX,MW], Flush[IF,ID,EX,MW]}
  function automatic logic [8:0] ctrl_word();
    return {PC_En, IFid__WE, IDex__WE, EXmem__WE, MEMwb__WE,
            IFid__Flush, IDex__Flush, EXmem__Flush, MEMwb__Flush};
  endfunction

  function automatic logic [8:0] exp_ctrl(bit in_init, bit ns, bit br, bit me, bit mr, bit ir);
    if (in_init)   return 9'b0_0000_1111;
    if (me && !mr) return 9'b0_0000_0001;
    if (ns)        return 9'b0_0001_0010;
    if (br)        return 9'b1_0011_1100;
    if (!ir)       return 9'b0_0111_1000;
    return 9'b1_1111_0000;
  endfunction

  function automatic int sat_inc(int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    init_left = INIT_CYCLES;
    wait_run  = 0;
    m_err     = 1'b0;
    m_sc      = 0;
    m_fc      = 0;
    m_wc      = 0;
  endtask

  task automatic check_regs();
    chk("mem_err",   {31'd0, Mem_Err}, {31'd0, m_err});
    chk("stall_cnt", 32'(Stall_Cnt), 32'(m_sc));
    chk("flush_cnt", 32'(Flush_Cnt), 32'(m_fc));
    chk("wait_cnt",  32'(Wait_Cnt),  32'(m_wc));
  endtask

  // One clock cycle: drive, check same-cycle controls, clock, update model, check registers.
  task automatic step(input bit ns, input bit br, input bit me, input bit mr, input bit ir, input bit clr);
    bit active, mwv;
    Need_Stall       = ns;
    EX__Branch_Taken = br;
    EXmem__MemEnable = me;
    Mem_Ready        = mr;
    IF__Imem_Ready   = ir;
    Clr_Cnt          = clr;
    #2;
    active = (init_left == 0);
    chk("ctrl", 32'(ctrl_word()), 32'(exp_ctrl(!active, ns, br, me, mr, ir)));
    @(posedge clk);
    #1;
    mwv = me && !mr;
    if (!active) begin
      init_left--;
    end else if (mwv) begin
      wait_run++;
      if (wait_run >= MEM_TIMEOUT) m_err = 1'b1;
    end else begin
      wait_run = 0;
    end
    if (clr) begin
      m_sc = 0; m_fc = 0; m_wc = 0;
    end else if (active) begin
      if (mwv)     m_wc = sat_inc(m_wc);
      else if (ns) m_sc = sat_inc(m_sc);
      else if (br) m_fc = sat_inc(m_fc);
    end
    check_regs();
  endtask

  // Assert reset mid-cycle, check the immediate reset outputs, release after an edge.
  task automatic do_reset();
    Need_Stall = 1'b0; EX__Branch_Taken = 1'b0; EXmem__MemEnable = 1'b0;
    Mem_Ready = 1'b0; IF__Imem_Ready = 1'b1; Clr_Cnt = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("reset_ctrl", 32'(ctrl_word()), 32'(9'b0_0000_1111));
    check_regs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    // Power-on reset values
    chk("por_ctrl", 32'(ctrl_word()), 32'(9'b0_0000_1111));
    check_regs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // INIT sequence with idle inputs, then the first RUN cycle
    for (int i = 0; i < INIT_CYCLES; i++) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // Load-use beats a simultaneous taken branch
    step(1, 1, 0, 0, 1, 0);
    chk("stall_over_branch_sc", 32'(Stall_Cnt), 32'd1);
    chk("stall_over_branch_fc", 32'(Flush_Cnt), 32'd0);

    // Branch redirect while instruction memory is not ready
    step(0, 1, 0, 0, 0, 0);
    chk("branch_no_imem_fc", 32'(Flush_Cnt), 32'd1);

    // Memory wait with load-use pending throughout
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 1, 0);
    chk("mem_wait_cnt3", 32'(Wait_Cnt), 32'd3);
    step(1, 0, 1, 1, 1, 0);
    chk("ready_loaduse_sc", 32'(Stall_Cnt), 32'd2);
    step(0, 0, 0, 0, 1, 0);

    // Timeout: sticky flag after the MEM_TIMEOUT-th wait cycle
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 0, 1, 0);
      chk("timeout_flag", {31'd0, Mem_Err}, (i >= MEM_TIMEOUT - 1) ? 32'd1 : 32'd0);
    end
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("timeout_sticky", {31'd0, Mem_Err}, 32'd1);

    // Stall counter saturation and clear-over-increment
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 1, 0);
    chk("stall_saturate", 32'(Stall_Cnt), 32'(CMAX));
    step(1, 0, 0, 0, 1, 1);
    chk("clr_beats_inc", 32'(Stall_Cnt), 32'd0);

    // Reset clears the sticky error and restarts INIT
    do_reset();
    chk("err_cleared", {31'd0, Mem_Err}, 32'd0);
    for (int i = 0; i < INIT_CYCLES + 2; i++) step(0, 0, 0, 0, 1, 0);

    // Random traffic with occasional mid-operation resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        bit me, mr;
        me = ($urandom_range(0, 2) == 0);
        mr = ($urandom_range(0, 3) != 0) && !(i >= 300 && i < 320);
        step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, me, mr,
             $urandom_range(0, 4) != 0, $urandom_range(0, 39) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
